// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the redirect-source encoding for the PC mux.
package cpu_pkg;

    localparam int          PC_INCR        = 4;
    localparam int          B_OFFSET_MSB   = 23;
    localparam int          B_OFFSET_LSB   = 0;
    localparam int          B_OFFSET_SHIFT = 2;
    localparam logic [31:0] RESET_VECTOR   = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR     = 32'h0000_0018;

    typedef enum logic [1:0] {
        RD_SEQ,
        RD_BRANCH,
        RD_RET,
        RD_IRQ
    } redirect_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: top pointer plus saturating count; a push
// while full overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [XLEN-1:0]  mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push) begin
            // Pointer advances even when full, so the oldest slot is the one reused.
            ptr_d        = ptr_q + PTR_W'(1);
            mem_d[ptr_d] = din;
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign top      = mem_q[ptr_q];
    assign empty    = (cnt_q == '0);
    assign overflow = ovf_q;

endmodule

// File: rtl/sign_extend.sv
// Sign-extends an IN_W-bit field to OUT_W bits (OUT_W must exceed IN_W).
module sign_extend #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    assign dout = {{(OUT_W - IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch PC with stall, relative branch, branch-with-link, RAS-predicted
// return and interrupt redirect. Optional trace outputs under PC_SEQ_TRACE_EN.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              OFFSET_W     = cpu_pkg::B_OFFSET_MSB - cpu_pkg::B_OFFSET_LSB + 1,
    parameter int              OFFSET_SHIFT = cpu_pkg::B_OFFSET_SHIFT,
    parameter int              PC_INCR      = cpu_pkg::PC_INCR,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(cpu_pkg::RESET_VECTOR),
    parameter logic [XLEN-1:0] IRQ_VECTOR   = XLEN'(cpu_pkg::IRQ_VECTOR),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] inst,
    input  logic            branch,
    input  logic            link,
    input  logic            ret,
    input  logic [XLEN-1:0] ret_target,
    input  logic            irq_req,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            link_we,
    output logic [XLEN-1:0] link_addr,
    output logic [XLEN-1:0] epc,
    output logic            irq_ack,
    output logic            ras_empty,
`ifdef PC_SEQ_TRACE_EN
    output logic [31:0]     taken_cnt,
    output logic [XLEN-1:0] last_src,
`endif
    output logic            ras_overflow
);

    import cpu_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] link_addr_q, link_addr_d;
    logic            link_we_q, link_we_d;
    logic            irq_ack_q, irq_ack_d;
    logic [XLEN-1:0] seq, off_sext, tgt, ras_top;
    logic            ras_push, ras_pop;
    redirect_t       sel;

    sign_extend #(.IN_W(OFFSET_W), .OUT_W(XLEN)) u_sext (
        .din  (inst[OFFSET_W-1:0]),
        .dout (off_sext)
    );

    if (OFFSET_W < XLEN) begin : g_unused_inst
        logic unused_inst_hi;
        assign unused_inst_hi = ^inst[XLEN-1:OFFSET_W];
    end

    assign seq = pc_q + XLEN'(PC_INCR);
    assign tgt = seq + (off_sext << OFFSET_SHIFT);

    always_comb begin
        if (irq_req)     sel = RD_IRQ;
        else if (ret)    sel = RD_RET;
        else if (branch) sel = RD_BRANCH;
        else             sel = RD_SEQ;
    end

    always_comb begin
        unique case (sel)
            RD_IRQ:    pc_next = IRQ_VECTOR;
            RD_RET:    pc_next = ras_empty ? ret_target : ras_top;
            RD_BRANCH: pc_next = tgt;
            default:   pc_next = seq;
        endcase
    end

    // Stack only moves on a taken edge, and an interrupt suppresses both push and pop.
    assign ras_push = !stall && (sel == RD_BRANCH) && link;
    assign ras_pop  = !stall && (sel == RD_RET);

    ras_stack #(.RAS_DEPTH(RAS_DEPTH), .XLEN(XLEN)) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .din      (seq),
        .top      (ras_top),
        .empty    (ras_empty),
        .overflow (ras_overflow)
    );

    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        link_addr_d = link_addr_q;
        link_we_d   = 1'b0;
        irq_ack_d   = 1'b0;
        if (!stall) begin
            pc_d = pc_next;
            if (sel == RD_IRQ) begin
                epc_d     = pc_q;
                irq_ack_d = 1'b1;
            end
            if (ras_push) begin
                link_addr_d = seq;
                link_we_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            epc_q       <= '0;
            link_addr_q <= '0;
            link_we_q   <= 1'b0;
            irq_ack_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            epc_q       <= epc_d;
            link_addr_q <= link_addr_d;
            link_we_q   <= link_we_d;
            irq_ack_q   <= irq_ack_d;
        end
    end

    assign pc_out    = pc_q;
    assign epc       = epc_q;
    assign link_addr = link_addr_q;
    assign link_we   = link_we_q;
    assign irq_ack   = irq_ack_q;

`ifdef PC_SEQ_TRACE_EN
    logic [31:0]     taken_cnt_q, taken_cnt_d;
    logic [XLEN-1:0] last_src_q, last_src_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        last_src_d  = last_src_q;
        if (!stall && (pc_next != seq)) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
            last_src_d  = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt_q <= '0;
            last_src_q  <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            last_src_q  <= last_src_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign last_src  = last_src_q;
`endif

endmodule
